// File: rtl/index_tag_fold_gen.sv
// Folded global-history index/tag generator for a TAGE-style predictor.
// Keeps incrementally folded history per bank and registers one lookup result per cycle.
`timescale 1ns/1ps
module index_tag_fold_gen #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned GLOB_LEN = 131,
  parameter logic [8*NUM_BANKS-1:0] HIST_LENS = {8'd130, 8'd44, 8'd15, 8'd8},
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned IL = 10,
  parameter int unsigned TAG_LEN = 8
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           upd_valid,
  input  logic                           upd_taken,
  input  logic                           hist_clear,
  input  logic                           lk_valid,
  output logic                           lk_ready,
  input  logic [ADDRESS_SIZE-1:0]        pc_addr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_BANKS*IL-1:0]        index_out,
  output logic [NUM_BANKS*TAG_LEN-1:0]   tag_out
);

  localparam int unsigned T1_LEN = TAG_LEN - 1;
  localparam int unsigned MAXW   = (IL > TAG_LEN) ? IL : TAG_LEN;

  logic [GLOB_LEN-1:0]             hist;
  logic [NUM_BANKS*IL-1:0]         fi_all;
  logic [NUM_BANKS*TAG_LEN-1:0]    ft0_all;
  logic [NUM_BANKS*T1_LEN-1:0]     ft1_all;
  logic [NUM_BANKS*IL-1:0]         index_c;
  logic [NUM_BANKS*TAG_LEN-1:0]    tag_c;
  logic                            accept;
  logic                            unused_bits;

  // One fold step within the low w bits: rotate left, insert newest, retire the bit aging out.
  function automatic logic [MAXW-1:0] fold_step(input logic [MAXW-1:0] f,
                                                input int unsigned w,
                                                input int unsigned pos,
                                                input logic b,
                                                input logic o);
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] r;
    mask = (MAXW'(1) << w) - MAXW'(1);
    r = ((f << 1) | (f >> (w - 1))) & mask;
    r = r ^ MAXW'(b);
    r = r ^ (MAXW'(o) << pos);
    return r;
  endfunction

  assign lk_ready    = !out_valid || out_ready;
  assign accept      = lk_valid && lk_ready;
  assign unused_bits = ^{pc_addr, hist};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hist <= '0;
    end else if (hist_clear) begin
      hist <= '0;
    end else if (upd_valid) begin
      hist <= {hist[GLOB_LEN-2:0], upd_taken};
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    localparam int unsigned L = 32'(HIST_LENS[8*k +: 8]);

    logic [IL-1:0]      fi_q;
    logic [TAG_LEN-1:0] ft0_q;
    logic [T1_LEN-1:0]  ft1_q;
    logic               old_bit;

    assign old_bit = hist[L-1];

    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        fi_q  <= '0;
        ft0_q <= '0;
        ft1_q <= '0;
      end else if (hist_clear) begin
        fi_q  <= '0;
        ft0_q <= '0;
        ft1_q <= '0;
      end else if (upd_valid) begin
        fi_q  <= IL'(fold_step(MAXW'(fi_q), IL, L % IL, upd_taken, old_bit));
        ft0_q <= TAG_LEN'(fold_step(MAXW'(ft0_q), TAG_LEN, L % TAG_LEN, upd_taken, old_bit));
        ft1_q <= T1_LEN'(fold_step(MAXW'(ft1_q), T1_LEN, L % T1_LEN, upd_taken, old_bit));
      end
    end

    assign fi_all[k*IL +: IL]           = fi_q;
    assign ft0_all[k*TAG_LEN +: TAG_LEN] = ft0_q;
    assign ft1_all[k*T1_LEN +: T1_LEN]   = ft1_q;

    // Lookups see the folds as registered, i.e. before any same-cycle update or clear.
    assign index_c[k*IL +: IL] = pc_addr[IL-1:0] ^ pc_addr[2*IL-1:IL] ^ fi_all[k*IL +: IL];
    assign tag_c[k*TAG_LEN +: TAG_LEN] = pc_addr[TAG_LEN-1:0] ^ ft0_all[k*TAG_LEN +: TAG_LEN]
                                         ^ {ft1_all[k*T1_LEN +: T1_LEN], 1'b0};
  end

  // Single output stage; hist_clear leaves it untouched.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      index_out <= '0;
      tag_out   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      index_out <= index_c;
      tag_out   <= tag_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_index_tag_fold_gen.sv
// Scoreboard bench for index_tag_fold_gen: reference history model, direct folds, directed steps.
`timescale 1ns/1ps
module tb_index_tag_fold_gen;

  localparam int unsigned NUM_BANKS    = 4;
  localparam int unsigned GLOB_LEN     = 131;
  localparam int unsigned ADDRESS_SIZE = 32;
  localparam int unsigned IL           = 10;
  localparam int unsigned TAG_LEN      = 8;
  localparam int unsigned T1           = TAG_LEN - 1;
  localparam int unsigned IW           = NUM_BANKS * IL;
  localparam int unsigned TW           = NUM_BANKS * TAG_LEN;
  localparam logic [8*NUM_BANKS-1:0] HIST_LENS = {8'd130, 8'd44, 8'd15, 8'd8};

  logic                    CLK = 1'b0;
  logic                    reset = 1'b1;
  logic                    upd_valid = 1'b0;
  logic                    upd_taken = 1'b0;
  logic                    hist_clear = 1'b0;
  logic                    lk_valid = 1'b0;
  logic                    lk_ready;
  logic [ADDRESS_SIZE-1:0] pc_addr = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [IW-1:0]           index_out;
  logic [TW-1:0]           tag_out;

  index_tag_fold_gen #(
    .NUM_BANKS(NUM_BANKS), .GLOB_LEN(GLOB_LEN), .HIST_LENS(HIST_LENS),
    .ADDRESS_SIZE(ADDRESS_SIZE), .IL(IL), .TAG_LEN(TAG_LEN)
  ) dut (
    .CLK(CLK), .reset(reset), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .hist_clear(hist_clear), .lk_valid(lk_valid), .lk_ready(lk_ready),
    .pc_addr(pc_addr), .out_valid(out_valid), .out_ready(out_ready),
    .index_out(index_out), .tag_out(tag_out)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
  } res_t;

  res_t                sb[$];
  res_t                last;
  logic [GLOB_LEN-1:0] mh = '0;
  int                  vectors = 0;
  int                  miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Direct fold of the l newest model bits into w-bit words.
  function automatic logic [31:0] dfold(input int unsigned l, input int unsigned w);
    logic [31:0] f;
    f = '0;
    for (int unsigned i = 0; i < l; i++) f[i % w] = f[i % w] ^ mh[i];
    return f;
  endfunction

  function automatic res_t expect_res(input logic [ADDRESS_SIZE-1:0] pc);
    res_t r;
    logic [31:0] fi, f0, f1;
    int unsigned l;
    r = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      l  = 32'(HIST_LENS[8*k +: 8]);
      fi = dfold(l, IL);
      f0 = dfold(l, TAG_LEN);
      f1 = dfold(l, T1);
      r.idx[k*IL +: IL] = pc[IL-1:0] ^ pc[2*IL-1:IL] ^ fi[IL-1:0];
      r.tag[k*TAG_LEN +: TAG_LEN] = pc[TAG_LEN-1:0] ^ f0[TAG_LEN-1:0] ^ {f1[T1-1:0], 1'b0};
    end
    return r;
  endfunction

  task automatic check_folds();
    int unsigned l;
    for (int k = 0; k < NUM_BANKS; k++) begin
      l = 32'(HIST_LENS[8*k +: 8]);
      chk($sformatf("fold_fi[%0d]", k),  64'(dut.fi_all[k*IL +: IL]),           64'(dfold(l, IL)));
      chk($sformatf("fold_ft0[%0d]", k), 64'(dut.ft0_all[k*TAG_LEN +: TAG_LEN]), 64'(dfold(l, TAG_LEN)));
      chk($sformatf("fold_ft1[%0d]", k), 64'(dut.ft1_all[k*T1 +: T1]),          64'(dfold(l, T1)));
    end
  endtask

  // Settle inputs, push on accept, clock once, advance the model, then pop and compare.
  task automatic step();
    logic acc, clr, upd, tk;
    #1;
    acc = lk_valid && lk_ready;
    clr = hist_clear;
    upd = upd_valid;
    tk  = upd_taken;
    if (acc) sb.push_back(expect_res(pc_addr));
    @(posedge CLK);
    if (clr) mh = '0;
    else if (upd) mh = {mh[GLOB_LEN-2:0], tk};
    #1;
    check_folds();
    if (acc) begin
      chk("out_valid_after_accept", 64'(out_valid), 64'(1'b1));
      last = sb.pop_front();
      chk("index_out", 64'(index_out), 64'(last.idx));
      chk("tag_out", 64'(tag_out), 64'(last.tag));
    end
  endtask

  task automatic drive(input logic lkv, input logic [ADDRESS_SIZE-1:0] pc, input logic ordy,
                       input logic upv, input logic tk, input logic clr);
    @(negedge CLK);
    lk_valid   = lkv;
    pc_addr    = pc;
    out_ready  = ordy;
    upd_valid  = upv;
    upd_taken  = tk;
    hist_clear = clr;
    step();
  endtask

  initial begin
    // Reset state.
    #3;
    chk("reset_out_valid", 64'(out_valid), 64'(1'b0));
    chk("reset_lk_ready", 64'(lk_ready), 64'(1'b1));
    chk("reset_index_out", 64'(index_out), 64'(0));
    chk("reset_tag_out", 64'(tag_out), 64'(0));
    check_folds();
    @(negedge CLK);
    reset = 1'b0;

    // Lookup on zero history.
    drive(1'b1, 32'h0000_0403, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_hist_tag", 64'(tag_out), 64'({NUM_BANKS{8'h03}}));

    // One taken update, then pc=0 lookup.
    drive(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("drain_out_valid", 64'(out_valid), 64'(1'b0));
    drive(1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("one_taken_index", 64'(index_out), 64'({NUM_BANKS{10'h001}}));
    chk("one_taken_tag", 64'(tag_out), 64'({NUM_BANKS{8'h03}}));

    // Random history traffic with interleaved lookups and consumer stalls.
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), ADDRESS_SIZE'($urandom()), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure: output held while the consumer stalls.
    drive(1'b1, ADDRESS_SIZE'($urandom()), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("stall_lk_ready", 64'(lk_ready), 64'(1'b0));
      chk("stall_out_valid", 64'(out_valid), 64'(1'b1));
      chk("stall_index_hold", 64'(index_out), 64'(last.idx));
      chk("stall_tag_hold", 64'(tag_out), 64'(last.tag));
    end
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);

    // Update, clear and lookup in the same cycle.
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, ADDRESS_SIZE'($urandom()), 1'b1, 1'b1, 1'b1, 1'b1);
    chk("post_clear_fi_zero", 64'(dut.fi_all), 64'(0));

    // Reset mid-flight with a result held.
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    drive(1'b1, ADDRESS_SIZE'($urandom()), 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    lk_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'(1'b0));
    chk("async_reset_index", 64'(index_out), 64'(0));
    chk("async_reset_lk_ready", 64'(lk_ready), 64'(1'b1));
    mh = '0;
    sb.delete();
    @(negedge CLK);
    reset = 1'b0;
    drive(1'b1, ADDRESS_SIZE'($urandom()), 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
